// File: rtl/dram_cmd_scheduler_if.sv
// Request handshake and DRAM command-trace signals of dram_cmd_scheduler.
// The master modport is the requester/trace side; the slave modport is the scheduler.
interface dram_cmd_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [32:0] req_address;
    logic        cmd_valid;
    logic [1:0]  cmd_type;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [7:0]  cmd_col;
    logic        done;
    logic        busy;

    modport master (
        output req_valid, req_opcode, req_address,
        input  req_ready, cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col, done, busy
    );

    modport slave (
        input  req_valid, req_opcode, req_address,
        output req_ready, cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col, done, busy
    );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Single-request in-order DRAM command scheduler: open-row tracking per bank, ACT/PRE/RD/WR
// sequencing under tRCD/tRP/tRAS/CL/CWL/burst timing. Define CLOSED_PAGE_EN for auto-precharge.
module dram_cmd_scheduler #(
    parameter int T_RCD   = 24,
    parameter int T_RP    = 24,
    parameter int T_RAS   = 52,
    parameter int T_CL    = 24,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    dram_cmd_scheduler_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_COL   = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
`ifdef CLOSED_PAGE_EN
    localparam logic [2:0] S_AUTOPRE = 3'd6;
`endif

    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_PRE = 2'd1;
    localparam logic [1:0] CMD_RD  = 2'd2;
    localparam logic [1:0] CMD_WR  = 2'd3;

    // Bank counters only need to reach the largest constraint; all-ones means "long ago".
    localparam int MAX_T  = (T_RAS > T_RP) ? ((T_RAS > T_RCD) ? T_RAS : T_RCD)
                                           : ((T_RP > T_RCD) ? T_RP : T_RCD);
    localparam int CNT_W  = $clog2(MAX_T + 1);
    localparam logic [CNT_W-1:0] RCD_C = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] RP_C  = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] RAS_C = CNT_W'(T_RAS);

    localparam int RD_LEN   = T_CL + T_BURST;
    localparam int WR_LEN   = T_CWL + T_BURST;
    localparam int DLEN_MAX = (RD_LEN > WR_LEN) ? RD_LEN : WR_LEN;
    localparam int DCNT_W   = $clog2(DLEN_MAX + 1);
    localparam logic [DCNT_W-1:0] RD_LEN_C = DCNT_W'(RD_LEN);
    localparam logic [DCNT_W-1:0] WR_LEN_C = DCNT_W'(WR_LEN);

    logic [2:0]        state;
    logic [DCNT_W-1:0] data_cnt;

    logic [1:0]  bg_q;
    logic [1:0]  bank_q;
    logic [14:0] row_q;
    logic [7:0]  col_q;
    logic        is_wr_q;
    logic [3:0]  bidx;

    logic [15:0]      open_q;
    logic [14:0]      open_row [16];
    logic [CNT_W-1:0] act_cnt [16];
    logic [CNT_W-1:0] pre_cnt [16];

    logic       accept;
    logic       in_pre;
    logic       issue_pre;
    logic       issue_act;
    logic       issue_col;
    logic       cmd_valid;
    logic       done;
    logic [1:0] type_now;

    logic [1:0]  hold_type;
    logic [1:0]  hold_bg;
    logic [1:0]  hold_bank;
    logic [14:0] hold_row;
    logic [7:0]  hold_col;

    logic unused_addr_bits;

    assign unused_addr_bits = ^bus.req_address[5:0];
    assign bidx   = {bg_q, bank_q};
    assign accept = (state == S_IDLE) && bus.req_valid;

`ifdef CLOSED_PAGE_EN
    assign in_pre = (state == S_PRE) || (state == S_AUTOPRE);
`else
    assign in_pre = (state == S_PRE);
`endif

    assign issue_pre = in_pre && (act_cnt[bidx] >= RAS_C);
    assign issue_act = (state == S_ACT) && (pre_cnt[bidx] >= RP_C);
    assign issue_col = (state == S_COL) && (act_cnt[bidx] >= RCD_C);
    assign cmd_valid = issue_pre || issue_act || issue_col;
    assign done      = (state == S_DATA) && (data_cnt == (is_wr_q ? WR_LEN_C : RD_LEN_C));

    always_comb begin
        type_now = is_wr_q ? CMD_WR : CMD_RD;
        if (issue_act) begin
            type_now = CMD_ACT;
        end else if (issue_pre) begin
            type_now = CMD_PRE;
        end
    end

    // Command fields show the issuing request this cycle, otherwise the last issued command.
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_type  = cmd_valid ? type_now : hold_type;
    assign bus.cmd_bg    = cmd_valid ? bg_q     : hold_bg;
    assign bus.cmd_bank  = cmd_valid ? bank_q   : hold_bank;
    assign bus.cmd_row   = cmd_valid ? row_q    : hold_row;
    assign bus.cmd_col   = cmd_valid ? col_q    : hold_col;
    assign bus.done      = done;
    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_type <= '0;
            hold_bg   <= '0;
            hold_bank <= '0;
            hold_row  <= '0;
            hold_col  <= '0;
        end else if (cmd_valid) begin
            hold_type <= type_now;
            hold_bg   <= bg_q;
            hold_bank <= bank_q;
            hold_row  <= row_q;
            hold_col  <= col_q;
        end
    end

    // Request fields and open-row values are only read when qualified by state/open bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            bg_q    <= bus.req_address[7:6];
            bank_q  <= bus.req_address[9:8];
            col_q   <= bus.req_address[17:10];
            row_q   <= bus.req_address[32:18];
            is_wr_q <= (bus.req_opcode == 2'd1);
        end
        if (issue_act) begin
            open_row[bidx] <= row_q;
        end
    end

    // Per-bank timing counters run in every state and saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                act_cnt[i] <= '1;
                pre_cnt[i] <= '1;
            end
            open_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (act_cnt[i] != '1) act_cnt[i] <= act_cnt[i] + CNT_W'(1);
                if (pre_cnt[i] != '1) pre_cnt[i] <= pre_cnt[i] + CNT_W'(1);
            end
            if (issue_act) begin
                act_cnt[bidx] <= CNT_W'(1);
                open_q[bidx]  <= 1'b1;
            end
            if (issue_pre) begin
                pre_cnt[bidx] <= CNT_W'(1);
                open_q[bidx]  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            data_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!open_q[bidx]) begin
                        state <= S_ACT;
                    end else if (open_row[bidx] == row_q) begin
                        state <= S_COL;
                    end else begin
                        state <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (issue_pre) state <= S_ACT;
                end
                S_ACT: begin
                    if (issue_act) state <= S_COL;
                end
                S_COL: begin
                    if (issue_col) begin
                        state    <= S_DATA;
                        data_cnt <= DCNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (done) begin
`ifdef CLOSED_PAGE_EN
                        state <= S_AUTOPRE;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        data_cnt <= data_cnt + DCNT_W'(1);
                    end
                end
`ifdef CLOSED_PAGE_EN
                S_AUTOPRE: begin
                    if (issue_pre) state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: command ordering, cycle spacing, fields, reset behaviour.
// Expected cycles are measured relative to the request acceptance cycle.
module tb_dram_cmd_scheduler;
    localparam int LIM = 300;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    dram_cmd_scheduler_if bus ();

    dram_cmd_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic bound_ok(input string tag, input int n);
        tests++;
        assert (n < LIM) else begin
            fails++;
            $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, LIM);
        end
    endtask

    // Present a request from a negedge; acc is the cycle in which the handshake is seen.
    task automatic send_req(input logic [1:0] op, input logic [32:0] addr, output int acc);
        int n = 0;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_opcode  = op;
        bus.req_address = addr;
        while (!bus.req_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        bound_ok("req_accept_wait", n);
        acc = cyc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_cmd(output int c, output int t, output int bg, output int bk,
                            output int row, output int col);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_valid && n < LIM);
        bound_ok("cmd_wait", n);
        c   = cyc;
        t   = int'(bus.cmd_type);
        bg  = int'(bus.cmd_bg);
        bk  = int'(bus.cmd_bank);
        row = int'(bus.cmd_row);
        col = int'(bus.cmd_col);
    endtask

    task automatic wait_done(output int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < LIM);
        bound_ok("done_wait", n);
        d = cyc;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},     int'(bus.req_ready), 1);
        chk({tag, "_busy"},      int'(bus.busy), 0);
        chk({tag, "_cmd_valid"}, int'(bus.cmd_valid), 0);
        chk({tag, "_cmd_type"},  int'(bus.cmd_type), 0);
        chk({tag, "_cmd_bg"},    int'(bus.cmd_bg), 0);
        chk({tag, "_cmd_bank"},  int'(bus.cmd_bank), 0);
        chk({tag, "_cmd_row"},   int'(bus.cmd_row), 0);
        chk({tag, "_cmd_col"},   int'(bus.cmd_col), 0);
        chk({tag, "_done"},      int'(bus.done), 0);
    endtask

    int a, c, t, bg, bk, row, col, d, act4, n;

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_opcode  = 2'd0;
        bus.req_address = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Read row 1, bank 0 on an empty bank
        send_req(2'd0, 33'h0_0004_0000, a);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t1_act_cycle", c - a, 2);
        chk("t1_act_type", t, 0);
        chk("t1_act_row", row, 1);
        chk("t1_act_bank", bg * 4 + bk, 0);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t1_rd_cycle", c - a, 26);
        chk("t1_rd_type", t, 2);
        chk("t1_rd_col", col, 0);
        wait_done(d);
        chk("t1_done_cycle", d - a, 54);
        chk("t1_busy_at_done", int'(bus.busy), 1);

`ifndef CLOSED_PAGE_EN
        // Same-row hit: no ACT, RD right after CHECK
        send_req(2'd0, 33'h0_0004_0000, a);
        chk("t2_accept_after_done", a - d, 1);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t2_rd_cycle", c - a, 2);
        chk("t2_rd_type", t, 2);
        wait_done(d);
        chk("t2_done_cycle", d - a, 30);

        // Row conflict on bank 0: PRE, ACT, RD
        send_req(2'd0, 33'h0_0008_0000, a);
        chk("t3_accept_after_done", a - d, 1);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t3_pre_cycle", c - a, 2);
        chk("t3_pre_type", t, 1);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t3_act_cycle", c - a, 26);
        chk("t3_act_type", t, 0);
        chk("t3_act_row", row, 2);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t3_rd_cycle", c - a, 50);
        chk("t3_rd_type", t, 2);
        wait_done(d);
        chk("t3_done_cycle", d - a, 78);

        // Write to bg 1 / bank 1, row 3, column 0xA5, nonzero ignored low bits
        send_req(2'd1, 33'h0_000E_956F, a);
        wait_cmd(c, t, bg, bk, row, col);
        act4 = c;
        chk("t4_act_cycle", c - a, 2);
        chk("t4_act_type", t, 0);
        chk("t4_act_bg", bg, 1);
        chk("t4_act_bank", bk, 1);
        chk("t4_act_row", row, 3);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t4_wr_cycle", c - a, 26);
        chk("t4_wr_type", t, 3);
        chk("t4_wr_col", col, 'hA5);
        chk("t4_wr_bg", bg, 1);
        chk("t4_wr_bank", bk, 1);
        wait_done(d);
        chk("t4_done_cycle", d - a, 50);

        // Conflict right after the write: PRE held back until ACT+tRAS
        send_req(2'd2, 33'h0_0010_0140, a);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t5_pre_after_act", c - act4, 52);
        chk("t5_pre_cycle", c - a, 3);
        chk("t5_pre_type", t, 1);
        chk("t5_pre_bank", bg * 4 + bk, 5);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t5_act_cycle", c - a, 27);
        chk("t5_act_row", row, 4);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t5_rd_cycle", c - a, 51);
        chk("t5_rd_type", t, 2);
        wait_done(d);
        chk("t5_done_cycle", d - a, 79);

        // Reset during DATA of a row hit
        send_req(2'd0, 33'h0_0008_0000, a);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t6_rd_cycle", c - a, 2);
        chk("t6_rd_type", t, 2);
        repeat (5) @(negedge clk);
        chk("t6_busy_before_rst", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_midrst");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("t6_no_done", n, 0);
        send_req(2'd0, 33'h0_0008_0000, a);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t6_act_cycle", c - a, 2);
        chk("t6_act_type", t, 0);
        chk("t6_act_row", row, 2);
        wait_cmd(c, t, bg, bk, row, col);
        chk("t6_rd_cycle2", c - a, 26);
        chk("t6_rd_type2", t, 2);
        wait_done(d);
        chk("t6_done_cycle", d - a, 54);
`else
        // Closed page: auto-precharge after each request, next same-row read re-activates
        wait_cmd(c, t, bg, bk, row, col);
        chk("cp_pre1_cycle", c - d, 1);
        chk("cp_pre1_type", t, 1);
        send_req(2'd0, 33'h0_0004_0000, a);
        chk("cp_accept_after_pre", a - c, 1);
        wait_cmd(c, t, bg, bk, row, col);
        chk("cp_act_cycle", c - a, 23);
        chk("cp_act_type", t, 0);
        chk("cp_act_row", row, 1);
        wait_cmd(c, t, bg, bk, row, col);
        chk("cp_rd_cycle", c - a, 47);
        chk("cp_rd_type", t, 2);
        wait_done(d);
        chk("cp_done_cycle", d - a, 75);
        wait_cmd(c, t, bg, bk, row, col);
        chk("cp_pre2_cycle", c - d, 1);
        chk("cp_pre2_type", t, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
